// File: rtl/data_extract_pkg.sv
// Shared receive-chain definitions: carrier allocation codes, sample field
// layout and the data_extract state encoding.
package data_extract_pkg;

    localparam int NSC_DEFAULT = 1680;

    // Allocation-vector carrier codes, 2 bits per carrier
    localparam logic [1:0] CAR_NULL    = 2'b00;
    localparam logic [1:0] CAR_PILOT_A = 2'b01;
    localparam logic [1:0] CAR_PILOT_B = 2'b10;
    localparam logic [1:0] CAR_DATA    = 2'b11;

    // Sample layout {Im, Re}, 16-bit signed each
    localparam int RE_LSB = 0;
    localparam int RE_MSB = 15;
    localparam int IM_LSB = 16;
    localparam int IM_MSB = 31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } de_state_t;

    function automatic logic car_is_data(input logic [1:0] code);
        return code == CAR_DATA;
    endfunction

endpackage

// File: rtl/data_extract_alloc_lookup.sv
// Frame-latched copy of the carrier allocation map and the per-carrier code
// lookup indexed by the running carrier index.
module alloc_lookup
    import data_extract_pkg::*;
#(
    parameter int NSC = NSC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_load,
    input  logic [2*NSC-1:0]         i_alloc_vec,
    input  logic [$clog2(NSC)-1:0]   i_sc_idx,
    output logic [1:0]               o_code
);

    logic [1:0] r_alloc [NSC];

    // NOTE: the map is always loaded at frame start before it is read, so it
    // carries no reset; resetting thousands of flops would buy nothing.
    always_ff @(posedge clk) begin
        if (i_load) begin
            for (int k = 0; k < NSC; k++) begin
                r_alloc[k] <= i_alloc_vec[2*k +: 2];
            end
        end
    end

    assign o_code = r_alloc[i_sc_idx];

endmodule

// File: rtl/data_extract.sv
// Drops pilot/null/reserved carriers from the phase-corrected stream and
// forwards data carriers in order; counts symbols and flags partial frames.
module data_extract
    import data_extract_pkg::*;
#(
    parameter int NSC  = NSC_DEFAULT,
    parameter int DW   = 32,
    parameter int SYMW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DW-1:0]      DAT_I,
    input  logic               CYC_I,
    input  logic               STB_I,
    input  logic               WE_I,
    output logic               ACK_O,
    output logic [DW-1:0]      DAT_O,
    output logic               CYC_O,
    output logic               STB_O,
    output logic               WE_O,
    input  logic               ACK_I,
    input  logic [2*NSC-1:0]   ALLOC_VEC,
    output logic [SYMW-1:0]    SYM_CNT,
    output logic               PART_SYM
);

    localparam int IDXW = $clog2(NSC);

    de_state_t         r_state;
    logic              r_cyc;
    logic              r_stb;
    logic [DW-1:0]     r_dat;
    logic [IDXW-1:0]   r_sc_idx;
    logic [SYMW-1:0]   r_sym_cnt;
    logic              r_part_sym;

    logic              w_frame_start;
    logic              w_in_xfer;
    logic [1:0]        w_code;
    logic              w_is_data;

    assign w_frame_start = (r_state == S_IDLE) && CYC_I;

    alloc_lookup #(.NSC(NSC)) u_alloc_lookup (
        .clk         (clk),
        .i_load      (w_frame_start),
        .i_alloc_vec (ALLOC_VEC),
        .i_sc_idx    (r_sc_idx),
        .o_code      (w_code)
    );

    assign w_is_data = car_is_data(w_code);

    // Accept only when the output register is free or being emptied this cycle
    assign ACK_O     = CYC_I && STB_I && WE_I && (r_state == S_RUN) && (!r_stb || ACK_I);
    assign w_in_xfer = ACK_O;

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_dat      <= '0;
            r_sc_idx   <= '0;
            r_sym_cnt  <= '0;
            r_part_sym <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (CYC_I) begin
                        r_state    <= S_RUN;
                        r_cyc      <= 1'b1;
                        r_sc_idx   <= '0;
                        r_sym_cnt  <= '0;
                        r_part_sym <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (!CYC_I) begin
                        r_state    <= S_FLUSH;
                        r_part_sym <= (r_sc_idx != '0);
                    end

                    if (w_in_xfer) begin
                        if (r_sc_idx == IDXW'(NSC - 1)) begin
                            r_sc_idx <= '0;
                            if (r_sym_cnt != '1) begin
                                r_sym_cnt <= r_sym_cnt + SYMW'(1);
                            end
                        end else begin
                            r_sc_idx <= r_sc_idx + IDXW'(1);
                        end
                    end

                    // A data transfer reloads even while the old sample is
                    // being taken, so back-to-back data has no bubble
                    if (w_in_xfer && w_is_data) begin
                        r_dat <= DAT_I;
                        r_stb <= 1'b1;
                    end else if (ACK_I) begin
                        r_stb <= 1'b0;
                    end
                end

                S_FLUSH: begin
                    if (!r_stb || ACK_I) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_dat   <= '0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CYC_O    = r_cyc;
    assign STB_O    = r_stb;
    assign WE_O     = r_stb;
    assign DAT_O    = r_dat;
    assign SYM_CNT  = r_sym_cnt;
    assign PART_SYM = r_part_sym;

endmodule

// File: tb/tb_data_extract.sv
// Directed bench for data_extract: a table of whole frames checked against a
// queue model built from the bench's own copy of the allocation map.
module tb_data_extract;

    localparam int NSC  = 1680;
    localparam int DW   = 32;
    localparam int SYMW = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [DW-1:0]      dat_i;
    logic               cyc_i, stb_i, we_i;
    logic               ack_o;
    logic [DW-1:0]      dat_o;
    logic               cyc_o, stb_o, we_o;
    logic               ack_i;
    logic [2*NSC-1:0]   alloc_vec;
    logic [SYMW-1:0]    sym_cnt;
    logic               part_sym;

    always #5 clk = ~clk;

    data_extract #(.NSC(NSC), .DW(DW), .SYMW(SYMW)) dut (
        .clk       (clk),
        .rst       (rst),
        .DAT_I     (dat_i),
        .CYC_I     (cyc_i),
        .STB_I     (stb_i),
        .WE_I      (we_i),
        .ACK_O     (ack_o),
        .DAT_O     (dat_o),
        .CYC_O     (cyc_o),
        .STB_O     (stb_o),
        .WE_O      (we_o),
        .ACK_I     (ack_i),
        .ALLOC_VEC (alloc_vec),
        .SYM_CNT   (sym_cnt),
        .PART_SYM  (part_sym)
    );

    typedef struct {
        int n;          // samples offered
        int ack_mode;   // 0: ACK_I high, 1: ACK_I toggles
        int zero_map;   // 1: all-zero map, else the 14-carrier pattern
        int change_at;  // sample index at which ALLOC_VEC is zeroed (-1 never)
        int exp_out;
        int exp_sym;
        int exp_part;
        int exp_first;  // Re of first output, -1 if none
        int exp_cyc;    // cycles to offer all samples, -1 don't care
        int exp_flush;  // cycles from CYC_I low to CYC_O low, -1 don't care
    } vec_t;

    vec_t tbl [7];

    logic [2*NSC-1:0] pat;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state
    logic [1:0]    m_map [NSC];
    logic [DW-1:0] exp_q [$];
    int            sent, out_cnt, order_err, hold_err, first_re, cyc;
    logic          prev_stall;
    logic [DW-1:0] prev_dat;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int s);
        return {16'(s / NSC), 16'(s % NSC)};
    endfunction

    task automatic load_model(input logic [2*NSC-1:0] map);
        for (int k = 0; k < NSC; k++) m_map[k] = map[2*k +: 2];
        exp_q.delete();
        sent = 0; out_cnt = 0; order_err = 0; hold_err = 0;
        first_re = -1; cyc = 0; prev_stall = 1'b0; prev_dat = '0;
    endtask

    // Called at a negedge with inputs already driven; samples, then advances
    // to the next negedge.
    task automatic step();
        logic acc;
        #1;
        acc = cyc_i & stb_i & we_i & ack_o;
        if (stb_o && ack_i) begin
            if (out_cnt == 0) first_re = int'(dat_o[15:0]);
            if (exp_q.size() == 0) order_err++;
            else begin
                if (exp_q[0] !== dat_o) order_err++;
                void'(exp_q.pop_front());
            end
            out_cnt++;
        end
        if (prev_stall && (!stb_o || dat_o !== prev_dat)) hold_err++;
        if (stb_o && !ack_i && ack_o) hold_err++;
        prev_stall = stb_o & ~ack_i;
        prev_dat   = dat_o;
        if (acc) begin
            if (m_map[sent % NSC] == 2'b11) exp_q.push_back(dat_i);
            sent++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_frame(input int id, input vec_t v);
        int budget;
        int send_cyc;
        int flush_steps;
        alloc_vec = (v.zero_map != 0) ? '0 : pat;
        load_model(alloc_vec);
        budget = 3 * v.n + 20;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
        while (sent < v.n && cyc < budget) begin
            if (sent == v.change_at) alloc_vec = '0;
            dat_i = mk(sent);
            ack_i = (v.ack_mode != 0) ? cyc[0] : 1'b1;
            step();
        end
        send_cyc = cyc;
        check($sformatf("v%0d_samples_accepted", id), sent, v.n);
        cyc_i = 1'b0; stb_i = 1'b0;
        flush_steps = 0;
        while (cyc_o && flush_steps < 50) begin
            ack_i = (v.ack_mode != 0) ? cyc[0] : 1'b1;
            step();
            flush_steps++;
        end
        ack_i = 1'b1;
        check($sformatf("v%0d_cyc_o_fell", id), cyc_o, 0);
        check($sformatf("v%0d_out_count", id), out_cnt, v.exp_out);
        check($sformatf("v%0d_order_errors", id), order_err + exp_q.size(), 0);
        check($sformatf("v%0d_hold_errors", id), hold_err, 0);
        check($sformatf("v%0d_sym_cnt", id), sym_cnt, v.exp_sym);
        check($sformatf("v%0d_part_sym", id), part_sym, v.exp_part);
        check($sformatf("v%0d_first_re", id), first_re, v.exp_first);
        check($sformatf("v%0d_idle_dat_o", id), {stb_o, we_o, dat_o}, 0);
        if (v.exp_cyc >= 0) check($sformatf("v%0d_send_cycles", id), send_cyc, v.exp_cyc);
        if (v.exp_flush >= 0) check($sformatf("v%0d_flush_cycles", id), flush_steps, v.exp_flush);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pat = {120{28'hFFFBFFD}};
        //          n     ack zero chg   out   sym part first cyc   flush
        tbl[0] = '{1680,  0,  0,   -1,   1440, 1,  0,   1,    1681, 2};
        tbl[1] = '{8400,  1,  0,   -1,   7200, 5,  0,   1,    -1,   -1};
        tbl[2] = '{1000,  0,  0,   -1,   857,  0,  1,   1,    1001, 2};
        tbl[3] = '{1680,  1,  0,   -1,   1440, 1,  0,   1,    -1,   -1};
        tbl[4] = '{1680,  0,  1,   -1,   0,    1,  0,   -1,   1681, 2};
        tbl[5] = '{3360,  0,  0,   500,  2880, 2,  0,   1,    3361, 2};
        tbl[6] = '{1700,  0,  0,   -1,   1457, 1,  1,   1,    1701, 2};

        rst = 1'b1; dat_i = '0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        ack_i = 1'b0; alloc_vec = pat;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_ack_o", ack_o, 0);
        check("rst_cyc_o", cyc_o, 0);
        check("rst_stb_we", {stb_o, we_o}, 0);
        check("rst_dat_o", dat_o, 0);
        check("rst_sym_cnt", sym_cnt, 0);
        check("rst_part_sym", part_sym, 0);

        // Frame start latency, backpressure, then reset mid-frame while stalled
        load_model(pat);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; ack_i = 1'b0; dat_i = mk(0);
        #1;
        check("idle_no_ack", ack_o, 0);
        @(negedge clk);
        check("start_cyc_o", cyc_o, 1);
        check("start_ack_o", ack_o, 1);
        step();
        dat_i = mk(1);
        step();
        dat_i = mk(2);
        check("bp_stb_o", stb_o, 1);
        check("bp_dat_o", dat_o, mk(1));
        check("bp_ack_o", ack_o, 0);
        step();
        check("bp_hold_dat_o", dat_o, mk(1));
        check("bp_hold_ack_o", ack_o, 0);
        rst = 1'b1;
        step();
        check("midrst_outputs", {ack_o, cyc_o, stb_o, we_o}, 0);
        check("midrst_dat_o", dat_o, 0);
        rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; ack_i = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_frame(i, tbl[i]);

        // Reset while idle clears the held frame status
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rst_sym_cnt", sym_cnt, 0);
        check("idle_rst_part_sym", part_sym, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
